hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows E/M/W occupancy to drive forwarding selects,
// load-use / RAW interlocks, multi-cycle execute stalls and branch flushes.
module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              UseRs1D,
    input  logic              UseRs2D,
    input  logic              RegWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              MulD,
    input  logic              PCSrcE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              busyE,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

    logic              r_eValid, r_eRegWrite, r_eMul;
    logic [REG_AW-1:0] r_eRd, r_eRs1, r_eRs2;
    logic [1:0]        r_eResultSrc;
    logic              r_mValid, r_mRegWrite;
    logic [REG_AW-1:0] r_mRd;
    logic              r_wValid, r_wRegWrite;
    logic [REG_AW-1:0] r_wRd;
    logic [3:0]        r_mulCnt;
    logic [CNT_W-1:0]  r_stallCount;

    logic w_busy, w_eHitsD, w_mHitsD, w_wHitsD;
    logic w_lwStall, w_rawStall, w_hazard, w_branch, w_eBubble;

    // A stage only counts as writing r when it is live and r is not x0.
    function automatic logic writes(input logic v, input logic we,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] r);
        return v && we && (rd == r) && (r != '0);
    endfunction

    assign w_busy   = r_eValid && r_eMul && (r_mulCnt != 4'd0);
    assign w_eHitsD = (UseRs1D && writes(r_eValid, r_eRegWrite, r_eRd, Rs1D)) ||
                      (UseRs2D && writes(r_eValid, r_eRegWrite, r_eRd, Rs2D));
    assign w_mHitsD = (UseRs1D && writes(r_mValid, r_mRegWrite, r_mRd, Rs1D)) ||
                      (UseRs2D && writes(r_mValid, r_mRegWrite, r_mRd, Rs2D));
    assign w_wHitsD = (UseRs1D && writes(r_wValid, r_wRegWrite, r_wRd, Rs1D)) ||
                      (UseRs2D && writes(r_wValid, r_wRegWrite, r_wRd, Rs2D));

    assign w_lwStall  = (FWD_EN != 0) && (r_eResultSrc == 2'b01) && w_eHitsD;
    assign w_rawStall = (FWD_EN == 0) && (w_eHitsD || w_mHitsD || w_wHitsD);
    assign w_hazard   = w_lwStall || w_rawStall;
    // Branch gating on reset keeps flushes quiet while the block is held in reset.
    assign w_branch   = reset && PCSrcE && !w_busy;

    assign busyE  = w_busy;
    assign stallE = w_busy;
    assign stallF = w_busy || (w_hazard && !w_branch);
    assign stallD = stallF;
    assign flushD = w_branch;
    assign flushE = w_branch || (w_hazard && !w_busy);
    assign stall_count = r_stallCount;
    assign w_eBubble = flushE || stallD;

    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (FWD_EN != 0) begin
            if (writes(r_mValid, r_mRegWrite, r_mRd, r_eRs1))      forwardAE = 2'b10;
            else if (writes(r_wValid, r_wRegWrite, r_wRd, r_eRs1)) forwardAE = 2'b01;
            if (writes(r_mValid, r_mRegWrite, r_mRd, r_eRs2))      forwardBE = 2'b10;
            else if (writes(r_wValid, r_wRegWrite, r_wRd, r_eRs2)) forwardBE = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_eValid     <= 1'b0;
            r_eRegWrite  <= 1'b0;
            r_eMul       <= 1'b0;
            r_eRd        <= '0;
            r_eRs1       <= '0;
            r_eRs2       <= '0;
            r_eResultSrc <= 2'b00;
            r_mValid     <= 1'b0;
            r_mRegWrite  <= 1'b0;
            r_mRd        <= '0;
            r_wValid     <= 1'b0;
            r_wRegWrite  <= 1'b0;
            r_wRd        <= '0;
            r_mulCnt     <= 4'd0;
            r_stallCount <= '0;
        end else begin
            if (!stallE) begin
                r_eValid     <= !w_eBubble;
                r_eRegWrite  <= RegWriteD;
                r_eMul       <= MulD;
                r_eRd        <= RdD;
                r_eRs1       <= Rs1D;
                r_eRs2       <= Rs2D;
                r_eResultSrc <= ResultSrcD;
                r_mulCnt     <= (MulD && !w_eBubble) ? MUL_INIT : 4'd0;
                r_mValid     <= r_eValid;
                r_mRegWrite  <= r_eRegWrite;
                r_mRd        <= r_eRd;
            end else begin
                // E is frozen on a multi-cycle op, so M sees bubbles meanwhile.
                r_mulCnt <= r_mulCnt - 4'd1;
                r_mValid <= 1'b0;
            end
            r_wValid    <= r_mValid;
            r_wRegWrite <= r_mRegWrite;
            r_wRd       <= r_mRd;
            if (stallF && (r_stallCount != '1))
                r_stallCount <= r_stallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding/stall instance plus FWD_EN=0 and
// MUL_LAT=1 instances sharing the same decode-stage stimulus.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] Rs1D = '0, Rs2D = '0, RdD = '0;
    logic       UseRs1D = 1'b0, UseRs2D = 1'b0, RegWriteD = 1'b0, MulD = 1'b0, PCSrcE = 1'b0;
    logic [1:0] ResultSrcD = 2'b00;

    logic        stallF, stallD, stallE, flushD, flushE, busyE;
    logic [1:0]  fwdA, fwdB;
    logic [15:0] stallCount;
    logic        stallF0, stallD0, stallE0, flushD0, flushE0, busyE0;
    logic [1:0]  fwdA0, fwdB0;
    logic [15:0] stallCount0;
    logic        stallF1, stallD1, stallE1, flushD1, flushE1, busyE1;
    logic [1:0]  fwdA1, fwdB1;
    logic [15:0] stallCount1;

    logic [5:0] ctl, ctl0, ctl1;
    assign ctl  = {stallF,  stallD,  stallE,  flushD,  flushE,  busyE};
    assign ctl0 = {stallF0, stallD0, stallE0, flushD0, flushE0, busyE0};
    assign ctl1 = {stallF1, stallD1, stallE1, flushD1, flushE1, busyE1};

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .MUL_LAT(4), .FWD_EN(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MulD(MulD), .PCSrcE(PCSrcE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushD(flushD),
        .flushE(flushE), .forwardAE(fwdA), .forwardBE(fwdB), .busyE(busyE),
        .stall_count(stallCount));

    hazard_ctrl #(.REG_AW(5), .MUL_LAT(4), .FWD_EN(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MulD(MulD), .PCSrcE(PCSrcE),
        .stallF(stallF0), .stallD(stallD0), .stallE(stallE0), .flushD(flushD0),
        .flushE(flushE0), .forwardAE(fwdA0), .forwardBE(fwdB0), .busyE(busyE0),
        .stall_count(stallCount0));

    hazard_ctrl #(.REG_AW(5), .MUL_LAT(1), .FWD_EN(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .RegWriteD(RegWriteD),
        .ResultSrcD(ResultSrcD), .MulD(MulD), .PCSrcE(PCSrcE),
        .stallF(stallF1), .stallD(stallD1), .stallE(stallE1), .flushD(flushD1),
        .flushE(flushE1), .forwardAE(fwdA1), .forwardBE(fwdB1), .busyE(busyE1),
        .stall_count(stallCount1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setD(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic we,
                        input logic [1:0] src, input logic mul);
        Rs1D = rs1; Rs2D = rs2; RdD = rd; UseRs1D = u1; UseRs2D = u2;
        RegWriteD = we; ResultSrcD = src; MulD = mul;
    endtask

    task automatic nopD();
        setD(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic doReset();
        nopD();
        PCSrcE = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        nopD();
        reset = 1'b0;
        PCSrcE = 1'b1;
        #2;
        tests++;
        if (ctl !== 6'b0 || {fwdA, fwdB} !== 4'b0 || stallCount !== 16'd0) begin
            failed++;
            $display("[TB] FAIL reset_outputs: ctl=%b fwd=%b cnt=%0d expected all zero", ctl, {fwdA, fwdB}, stallCount);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        PCSrcE = 1'b0;
        tick();
        tests++;
        if (ctl !== 6'b0 || stallCount !== 16'd0) begin
            failed++;
            $display("[TB] FAIL reset_release: ctl=%b cnt=%0d expected 0/0", ctl, stallCount);
        end
    endtask

    task automatic test_forward();
        doReset();
        setD(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        tick();
        setD(5'd5, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        tests++;
        if (ctl !== 6'b0) begin
            failed++;
            $display("[TB] FAIL fwd_m_nostall: ctl=%b expected 000000", ctl);
        end
        tick();
        nopD();
        @(negedge clk);
        tests++;
        if (fwdA !== 2'b10 || fwdB !== 2'b00) begin
            failed++;
            $display("[TB] FAIL fwd_m: A=%b B=%b expected 10/00", fwdA, fwdB);
        end
        tick();
        setD(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        tick();
        setD(5'd11, 5'd12, 5'd10, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        tick();
        setD(5'd5, 5'd3, 5'd6, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        tick();
        nopD();
        @(negedge clk);
        tests++;
        if (fwdA !== 2'b01 || fwdB !== 2'b00 || ctl !== 6'b0 || stallCount !== 16'd0) begin
            failed++;
            $display("[TB] FAIL fwd_w: A=%b B=%b ctl=%b cnt=%0d expected 01/00/000000/0", fwdA, fwdB, ctl, stallCount);
        end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        setD(5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        tick();
        setD(5'd6, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        tests++;
        if (ctl !== 6'b110010) begin
            failed++;
            $display("[TB] FAIL lw_stall: ctl=%b expected 110010", ctl);
        end
        tick();
        @(negedge clk);
        tests++;
        if (ctl !== 6'b0) begin
            failed++;
            $display("[TB] FAIL lw_one_cycle: ctl=%b expected 000000", ctl);
        end
        tick();
        nopD();
        @(negedge clk);
        tests++;
        if (fwdA !== 2'b01 || stallCount !== 16'd1) begin
            failed++;
            $display("[TB] FAIL lw_fwd: A=%b cnt=%0d expected 01/1", fwdA, stallCount);
        end
        tick();
    endtask

    task automatic test_x0();
        doReset();
        setD(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        tick();
        setD(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        @(negedge clk);
        tests++;
        if (ctl !== 6'b0 || ctl0 !== 6'b0) begin
            failed++;
            $display("[TB] FAIL x0_nostall: ctl=%b ctl0=%b expected 000000", ctl, ctl0);
        end
        tick();
        nopD();
        @(negedge clk);
        tests++;
        if (fwdA !== 2'b00 || fwdB !== 2'b00) begin
            failed++;
            $display("[TB] FAIL x0_fwd: A=%b B=%b expected 00/00", fwdA, fwdB);
        end
        tick();
    endtask

    task automatic test_mul();
        doReset();
        setD(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
        tick();
        setD(5'd8, 5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            PCSrcE = (i == 1);
            @(negedge clk);
            tests++;
            if (ctl !== 6'b111001) begin
                failed++;
                $display("[TB] FAIL mul_busy[%0d]: ctl=%b expected 111001", i, ctl);
            end
            if (i == 0) begin
                tests++;
                if (ctl1 !== 6'b0) begin
                    failed++;
                    $display("[TB] FAIL mul_lat1_nostall: ctl=%b expected 000000", ctl1);
                end
            end
            if (i == 1) begin
                tests++;
                if (fwdA1 !== 2'b10) begin
                    failed++;
                    $display("[TB] FAIL mul_lat1_fwd: A=%b expected 10", fwdA1);
                end
            end
            tick();
        end
        PCSrcE = 1'b0;
        @(negedge clk);
        tests++;
        if (ctl !== 6'b0) begin
            failed++;
            $display("[TB] FAIL mul_release: ctl=%b expected 000000", ctl);
        end
        tick();
        nopD();
        @(negedge clk);
        tests++;
        if (fwdA !== 2'b10 || stallCount !== 16'd3) begin
            failed++;
            $display("[TB] FAIL mul_fwd: A=%b cnt=%0d expected 10/3", fwdA, stallCount);
        end
        tick();
    endtask

    task automatic test_branch();
        doReset();
        setD(5'd2, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0);
        tick();
        setD(5'd6, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        PCSrcE = 1'b1;
        @(negedge clk);
        tests++;
        if (ctl !== 6'b000110) begin
            failed++;
            $display("[TB] FAIL branch_wins: ctl=%b expected 000110", ctl);
        end
        tick();
        PCSrcE = 1'b0;
        nopD();
        @(negedge clk);
        tests++;
        if (ctl !== 6'b0 || stallCount !== 16'd0) begin
            failed++;
            $display("[TB] FAIL branch_after: ctl=%b cnt=%0d expected 000000/0", ctl, stallCount);
        end
        tick();
    endtask

    task automatic test_raw_nofwd();
        doReset();
        setD(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        tick();
        setD(5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (ctl0 !== 6'b110010 || {fwdA0, fwdB0} !== 4'b0) begin
                failed++;
                $display("[TB] FAIL raw_stall[%0d]: ctl=%b fwd=%b expected 110010/0000", i, ctl0, {fwdA0, fwdB0});
            end
            tick();
        end
        @(negedge clk);
        tests++;
        if (ctl0 !== 6'b0) begin
            failed++;
            $display("[TB] FAIL raw_release: ctl=%b expected 000000", ctl0);
        end
        tick();
        nopD();
        @(negedge clk);
        tests++;
        if ({fwdA0, fwdB0} !== 4'b0 || stallCount0 !== 16'd3) begin
            failed++;
            $display("[TB] FAIL raw_after: fwd=%b cnt=%0d expected 0000/3", {fwdA0, fwdB0}, stallCount0);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        doReset();
        setD(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1);
        tick();
        nopD();
        tick();
        #2;
        PCSrcE = 1'b1;
        reset = 1'b0;
        #1;
        tests++;
        if (ctl !== 6'b0 || {fwdA, fwdB} !== 4'b0 || stallCount !== 16'd0) begin
            failed++;
            $display("[TB] FAIL reset_mid_mul: ctl=%b fwd=%b cnt=%0d expected all zero", ctl, {fwdA, fwdB}, stallCount);
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        PCSrcE = 1'b0;
        tick();
        tests++;
        if (busyE !== 1'b0 || stallCount !== 16'd0) begin
            failed++;
            $display("[TB] FAIL mul_abort: busy=%b cnt=%0d expected 0/0", busyE, stallCount);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_x0();
        test_mul();
        test_branch();
        test_raw_nofwd();
        test_reset_mid_mul();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
